// File: rtl/counter_updown_async_reset.sv
// Purpose: parametrised up/down counter with prescaler, clear/load, wrap or saturate, boundary flags.
// Latency: result/wrap_pulse registered (1 clk after the qualifying edge); terminal_count combinational.
// Backpressure: none; every control input is sampled on every rising clk edge.
module counter_updown_async_reset #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}},
  parameter int unsigned      PRESCALE  = 1,
  parameter bit               SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             up_down,
  output logic [WIDTH-1:0] result,
  output logic             terminal_count,
  output logic             wrap_pulse
);

  // Prescaler holds the phase within one step period; at least one bit wide
  // so the PRESCALE=1 build still has a legal (constant-zero) register.
  localparam int unsigned      PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0]  PS_ZERO = '0;
  localparam logic [WIDTH-1:0] ZERO    = '0;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] result_q, result_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic             wrap_q, wrap_d;

  logic             at_top;
  logic             at_bottom;
  logic             step;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] step_val;
  logic             step_boundary;

  // Boundary decode, step qualification and load clamping.
  always_comb begin
    at_top       = (result_q == MAX_VALUE);
    at_bottom    = (result_q == ZERO);
    step         = enable && (ps_q == PS_LAST);
    load_clamped = (load_value > MAX_VALUE) ? MAX_VALUE : load_value;
  end

  // Value the counter takes if this cycle is a step, and whether it hits a boundary.
  always_comb begin
    step_val      = result_q;
    step_boundary = 1'b0;
    if (up_down) begin
      if (at_top) begin
        step_boundary = 1'b1;
        step_val      = SATURATE ? MAX_VALUE : ZERO;
      end else begin
        step_val = result_q + ONE;
      end
    end else begin
      if (at_bottom) begin
        step_boundary = 1'b1;
        step_val      = SATURATE ? ZERO : MAX_VALUE;
      end else begin
        step_val = result_q - ONE;
      end
    end
  end

  // Next state in priority order: clear, load, enabled counting, hold.
  // wrap_pulse defaults low so it only lives for the cycle after a boundary step.
  always_comb begin
    result_d = result_q;
    ps_d     = ps_q;
    wrap_d   = 1'b0;
    if (clear) begin
      result_d = ZERO;
      ps_d     = PS_ZERO;
    end else if (load) begin
      result_d = load_clamped;
      ps_d     = PS_ZERO;
    end else if (enable) begin
      if (step) begin
        ps_d     = PS_ZERO;
        result_d = step_val;
        wrap_d   = step_boundary;
      end else begin
        ps_d = ps_q + PS_W'(1);
      end
    end
  end

  // State registers; reset discards any pending prescaler phase immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= ZERO;
      ps_q     <= PS_ZERO;
      wrap_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      ps_q     <= ps_d;
      wrap_q   <= wrap_d;
    end
  end

  // Terminal count looks at the boundary in the currently selected direction.
  always_comb begin
    result         = result_q;
    wrap_pulse     = wrap_q;
    terminal_count = up_down ? at_top : at_bottom;
  end

endmodule

// File: tb/tb_counter_updown_async_reset.sv
module tb_counter_updown_async_reset;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'd0;
  logic       enable = 1'b0;
  logic       up_down = 1'b0;

  logic [7:0] res0, res1, res2, res3;
  logic       tc0, tc1, tc2, tc3;
  logic       wp0, wp1, wp2, wp3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         dut;
    logic [7:0] res;
    logic       tc;
    logic       wp;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  // dut 0: MAX 9, wrap, no prescale
  counter_updown_async_reset #(.WIDTH(8), .MAX_VALUE(8'd9), .PRESCALE(1), .SATURATE(1'b0)) u0 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
    .enable(enable), .up_down(up_down), .result(res0), .terminal_count(tc0), .wrap_pulse(wp0));
  // dut 1: MAX 9, saturate
  counter_updown_async_reset #(.WIDTH(8), .MAX_VALUE(8'd9), .PRESCALE(1), .SATURATE(1'b1)) u1 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
    .enable(enable), .up_down(up_down), .result(res1), .terminal_count(tc1), .wrap_pulse(wp1));
  // dut 2: MAX 255, prescale 4, wrap
  counter_updown_async_reset #(.WIDTH(8), .MAX_VALUE(8'd255), .PRESCALE(4), .SATURATE(1'b0)) u2 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
    .enable(enable), .up_down(up_down), .result(res2), .terminal_count(tc2), .wrap_pulse(wp2));
  // dut 3: defaults (MAX 255, no prescale, wrap)
  counter_updown_async_reset #(.WIDTH(8)) u3 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
    .enable(enable), .up_down(up_down), .result(res3), .terminal_count(tc3), .wrap_pulse(wp3));

  // Drive one cycle of inputs at the falling edge and queue the outputs
  // expected just after the following rising edge.
  task automatic drive(input logic r, input logic c, input logic l, input logic [7:0] lv,
                       input logic en, input logic ud, input int d,
                       input logic [7:0] er, input logic etc, input logic ewp, input string nm);
    exp_t e;
    @(negedge clk);
    reset = r; clear = c; load = l; load_value = lv; enable = en; up_down = ud;
    e.dut = d; e.res = er; e.tc = etc; e.wp = ewp; e.name = nm;
    exp_q.push_back(e);
  endtask

  // Raise reset between clock edges; the monitor samples before the next rising edge.
  task automatic async_rst(input int d, input logic ud, input string nm);
    exp_t e;
    @(negedge clk);
    enable = 1'b1; up_down = ud; clear = 1'b0; load = 1'b0;
    e.dut = d; e.res = 8'd0; e.tc = ~ud; e.wp = 1'b0; e.name = nm;
    exp_q.push_back(e);
    #2 reset = 1'b1;
  endtask

  // Monitor: every rising clk or reset edge, pop one expectation (if any) and compare.
  initial begin
    exp_t       e;
    logic [7:0] ar;
    logic       atc, awp;
    forever begin
      @(posedge clk or posedge reset);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e.dut)
          0:       begin ar = res0; atc = tc0; awp = wp0; end
          1:       begin ar = res1; atc = tc1; awp = wp1; end
          2:       begin ar = res2; atc = tc2; awp = wp2; end
          default: begin ar = res3; atc = tc3; awp = wp3; end
        endcase
        checks += 3;
        if (ar !== e.res) begin
          errors++;
          $display("FAIL %s result: got %0d want %0d", e.name, ar, e.res);
        end
        if (atc !== e.tc) begin
          errors++;
          $display("FAIL %s terminal_count: got %b want %b", e.name, atc, e.tc);
        end
        if (awp !== e.wp) begin
          errors++;
          $display("FAIL %s wrap_pulse: got %b want %b", e.name, awp, e.wp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // ---- dut 0: reset, up wrap, priority, async reset, clamp ----
    drive(1, 0, 0, 8'd0, 0, 0, 0, 8'd0, 1'b1, 1'b0, "reset_hold");
    for (int i = 1; i <= 12; i++)
      drive(0, 0, 0, 8'd0, 1, 1, 0, 8'(i % 10), (i % 10) == 9, i == 10, "up_wrap");
    drive(0, 1, 1, 8'd7, 1, 1, 0, 8'd0, 1'b0, 1'b0, "clear_priority");
    for (int i = 1; i <= 5; i++)
      drive(0, 0, 0, 8'd0, 1, 1, 0, 8'(i), 1'b0, 1'b0, "count_to_5");
    async_rst(0, 1'b1, "async_reset");
    drive(1, 0, 0, 8'd0, 1, 1, 0, 8'd0, 1'b0, 1'b0, "reset_held");
    drive(0, 0, 0, 8'd0, 1, 1, 0, 8'd1, 1'b0, 1'b0, "post_reset_step");
    drive(0, 0, 1, 8'd200, 1, 1, 0, 8'd9, 1'b1, 1'b0, "load_clamp");
    drive(0, 0, 1, 8'd4, 1, 1, 0, 8'd4, 1'b0, 1'b0, "load_over_enable");
    drive(0, 0, 0, 8'd0, 1, 1, 0, 8'd5, 1'b0, 1'b0, "step_after_load");

    // ---- dut 1: down saturate, up saturate ----
    drive(0, 0, 1, 8'd2, 0, 0, 1, 8'd2, 1'b0, 1'b0, "sat_load2");
    drive(0, 0, 0, 8'd0, 1, 0, 1, 8'd1, 1'b0, 1'b0, "sat_down1");
    drive(0, 0, 0, 8'd0, 1, 0, 1, 8'd0, 1'b1, 1'b0, "sat_down2");
    drive(0, 0, 0, 8'd0, 1, 0, 1, 8'd0, 1'b1, 1'b1, "sat_down3");
    drive(0, 0, 0, 8'd0, 1, 0, 1, 8'd0, 1'b1, 1'b1, "sat_down4");
    drive(0, 0, 0, 8'd0, 0, 0, 1, 8'd0, 1'b1, 1'b0, "sat_idle");
    drive(0, 0, 1, 8'd200, 0, 1, 1, 8'd9, 1'b1, 1'b0, "sat_load_top");
    drive(0, 0, 0, 8'd0, 1, 1, 1, 8'd9, 1'b1, 1'b1, "sat_up_pinned");

    // ---- dut 2: prescaler 4 with mid-phase hold, then reset discarding a phase ----
    drive(0, 1, 0, 8'd0, 0, 1, 2, 8'd0, 1'b0, 1'b0, "ps_clear");
    for (int k = 1; k <= 6; k++)
      drive(0, 0, 0, 8'd0, 1, 1, 2, 8'(k / 4), 1'b0, 1'b0, "ps_count");
    for (int k = 0; k < 2; k++)
      drive(0, 0, 0, 8'd0, 0, 1, 2, 8'd1, 1'b0, 1'b0, "ps_hold");
    for (int k = 7; k <= 12; k++)
      drive(0, 0, 0, 8'd0, 1, 1, 2, 8'(k / 4), 1'b0, 1'b0, "ps_resume");
    for (int k = 0; k < 2; k++)
      drive(0, 0, 0, 8'd0, 1, 1, 2, 8'd3, 1'b0, 1'b0, "ps_partial");
    async_rst(2, 1'b1, "ps_async_reset");
    for (int k = 1; k <= 4; k++)
      drive(0, 0, 0, 8'd0, 1, 1, 2, (k == 4) ? 8'd1 : 8'd0, 1'b0, 1'b0, "ps_after_reset");

    // ---- dut 3: direction flip at boundary, MAX 255 ----
    drive(0, 1, 0, 8'd0, 0, 0, 3, 8'd0, 1'b1, 1'b0, "flip_clear");
    drive(0, 0, 0, 8'd0, 1, 0, 3, 8'd255, 1'b0, 1'b1, "flip_down_wrap");
    drive(0, 0, 0, 8'd0, 1, 0, 3, 8'd254, 1'b0, 1'b0, "flip_down");
    drive(0, 0, 0, 8'd0, 1, 1, 3, 8'd255, 1'b1, 1'b0, "flip_up");
    drive(0, 0, 0, 8'd0, 1, 1, 3, 8'd0, 1'b0, 1'b1, "flip_up_wrap");

    @(negedge clk);
    enable = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
